// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the 4-digit multiplexed 7-segment
// display controller.
//   N_DIG    - number of multiplexed digits
//   AN_OFF   - anode pattern with every digit dark (anodes active-low)
//   SEG_OFF  - segment pattern with every segment dark (active-low)
//   HEX_SEG  - active-low g..a patterns for hex values 0x0..0xF
//   commit_st_t - commit state machine encoding
package display_pkg;

  localparam int N_DIG = 4;
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry [v] is the pattern for hex value v; bit 6 = g ... bit 0 = a.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {ST_IDLE, ST_PEND} commit_st_t;

endpackage

// File: rtl/control_display_hex7seg.sv
// hex7seg: combinational hex to 7-segment decoder.
//   hex - 4-bit value 0x0..0xF
//   seg - active-low segments, bit 6 = g ... bit 0 = a
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/control_display.sv
// control_display: scan controller for a 4-digit multiplexed 7-segment
// display. Time-slices the segment bus across the digits, double-buffers
// digit contents (shadow written by the game, active shown, copied on a
// commit at a frame boundary), and applies per-digit blanking plus 8-level
// PWM brightness. Optional blink support is built when DISPLAY_BLINK_EN is
// defined.
//   clk, rst_n          - clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_dp - shadow digit write port
//   blank[3:0]          - live per-digit blank mask (1 = dark)
//   bright[2:0]         - brightness, duty (bright+1)/8
//   commit              - request shadow->active copy at next frame boundary
//   blink[3:0]          - per-digit blink mask (DISPLAY_BLINK_EN only)
//   busy                - commit pending
//   done                - one-cycle pulse on the copy cycle
//   an[3:0], seg[6:0], dp - active-low display pins, registered
module control_display
  import display_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [3:0] blank,
  input  logic [2:0] bright,
  input  logic       commit,
`ifdef DISPLAY_BLINK_EN
  input  logic [3:0] blink,
`endif
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0]            cnt_p0;
  logic [1:0]               idx_p0;
  logic [2:0]               pwm_p0;
  logic                     slot_end, fb, pre_fb;
  logic [N_DIG-1:0]         blink_off;
  logic [N_DIG-1:0][4:0]    shadow, active;
  commit_st_t               state_p0;
  logic                     done_p1;
  logic [4:0]               cur_p0;
  logic [6:0]               seg_dec_p0;
  logic                     lit_p0;
  logic [3:0]               an_p1;
  logic [6:0]               seg_p1;
  logic                     dp_p1;

  assign slot_end = (cnt_p0 == CW'(CLK_DIV - 1));
  assign fb       = slot_end && (idx_p0 == 2'd3);
  // Cycle just before a frame boundary; lets done be registered yet high
  // exactly on the copy cycle.
  assign pre_fb   = (cnt_p0 == CW'(CLK_DIV - 2)) && (idx_p0 == 2'd3);

  // Slot timing: cnt within a digit slot, idx selects the digit, pwm is free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
      pwm_p0 <= '0;
    end else begin
      pwm_p0 <= pwm_p0 + 3'd1;
      if (slot_end) begin
        cnt_p0 <= '0;
        idx_p0 <= idx_p0 + 2'd1;
      end else begin
        cnt_p0 <= cnt_p0 + CW'(1);
      end
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt;
  logic          phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (fb) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign blink_off = phase ? blink : '0;
`else
  logic [31:0] unused_blink_frames;
  assign unused_blink_frames = BLINK_FRAMES;
  assign blink_off = '0;
`endif

  // Shadow buffer: game-side writes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[wr_addr] <= {wr_dp, wr_data};
    end
  end

  // Commit FSM; the copy reads shadow before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_IDLE;
      done_p1  <= 1'b0;
      active   <= '0;
    end else begin
      done_p1 <= pre_fb && ((state_p0 == ST_PEND) || commit);
      case (state_p0)
        ST_IDLE: if (commit) state_p0 <= ST_PEND;
        ST_PEND: if (fb) begin
          active   <= shadow;
          state_p0 <= ST_IDLE;
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_p0 == ST_PEND);
  assign done = done_p1;

  // Stage p0: digit select, decode and lit decision.
  assign cur_p0 = active[idx_p0];

  hex7seg u_hex7seg (
    .hex (cur_p0[3:0]),
    .seg (seg_dec_p0)
  );

  assign lit_p0 = (cnt_p0 >= CW'(DEAD_CYC)) && (pwm_p0 <= bright) &&
                  !blank[idx_p0] && !blink_off[idx_p0];

  // Stage p1: registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= lit_p0 ? ~(4'b0001 << idx_p0) : AN_OFF;
      seg_p1 <= lit_p0 ? seg_dec_p0 : SEG_OFF;
      dp_p1  <= lit_p0 ? ~cur_p0[4] : 1'b1;
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = dp_p1;

endmodule

// File: tb/tb_control_display.sv
// Testbench for control_display with CLK_DIV=20, DEAD_CYC=2, BLINK_FRAMES=2.
// A time-based model (cycle number since reset) predicts every output each
// cycle; directed pins check hand-computed values at chosen cycles.
module tb_control_display;

  localparam int CD = 20;
  localparam int DC = 2;
  localparam int BF = 2;
  localparam int FR = 4 * CD;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic [3:0] blank;
  logic [2:0] bright;
  logic       commit;
  logic [3:0] blink;
  logic       busy, done, dp;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int done_cnt = 0;

  control_display #(.CLK_DIV(CD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_dp   (wr_dp),
    .blank   (blank),
    .bright  (bright),
    .commit  (commit),
`ifdef DISPLAY_BLINK_EN
    .blink   (blink),
`endif
    .busy    (busy),
    .done    (done),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (time %0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [6:0] segtab(input logic [3:0] v);
    case (v)
      4'h0: segtab = 7'h40; 4'h1: segtab = 7'h79; 4'h2: segtab = 7'h24; 4'h3: segtab = 7'h30;
      4'h4: segtab = 7'h19; 4'h5: segtab = 7'h12; 4'h6: segtab = 7'h02; 4'h7: segtab = 7'h78;
      4'h8: segtab = 7'h00; 4'h9: segtab = 7'h10; 4'hA: segtab = 7'h08; 4'hB: segtab = 7'h03;
      4'hC: segtab = 7'h46; 4'hD: segtab = 7'h21; 4'hE: segtab = 7'h06; default: segtab = 7'h0E;
    endcase
  endfunction

  // Model state: t = clock edges seen since reset release.
  int         t;
  bit         pend;
  logic [4:0] act_m [4];
  logic [4:0] shd_m [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  task automatic model_reset();
    t = 0;
    pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      act_m[i] = '0;
      shd_m[i] = '0;
    end
    e_an = 4'hF;
    e_seg = 7'h7F;
    e_dp = 1'b1;
  endtask

  // Compare on the falling edge, then advance the model past the next rising edge.
  initial begin
    int  idx, ph;
    bit  lit, fbm;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      fbm = (rst_n === 1'b1) && ((t % FR) == FR - 1);
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("busy", 32'(busy), 32'(pend));
      chk("done", 32'(done), 32'(pend && fbm));
      if (done === 1'b1) done_cnt++;
      if (rst_n) begin
        idx = (t / CD) % 4;
`ifdef DISPLAY_BLINK_EN
        ph = (t / (FR * BF)) % 2;
`else
        ph = 0;
`endif
        lit = ((t % CD) >= DC) && ((t % 8) <= int'(bright)) && !blank[idx] &&
              !((ph == 1) && blink[idx]);
        e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
        e_seg = lit ? segtab(act_m[idx][3:0]) : 7'h7F;
        e_dp  = lit ? ~act_m[idx][4] : 1'b1;
        if (pend && fbm) begin
          for (int i = 0; i < 4; i++) act_m[i] = shd_m[i];
          pend = 1'b0;
        end else if (!pend && commit) begin
          pend = 1'b1;
        end
        if (wr_en) shd_m[wr_addr] = {wr_dp, wr_data};
        t++;
      end
    end
  end

  task automatic step_to(input int target);
    while (k < target) begin
      @(posedge clk);
      #2;
      k++;
    end
  endtask

  initial begin
    int n, d0, exp_f2;
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; wr_dp = 1'b0;
    blank = 4'b0000; bright = 3'd7; commit = 1'b0; blink = 4'b0000;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_an", 32'(an), 32'h0F);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    k = 0;

    step_to(2);   chk("an_dead", 32'(an), 32'hF);
    step_to(3);   chk("first_lit_an", 32'(an), 32'hE);
                  chk("first_lit_seg", 32'(seg), 32'h40);
                  chk("first_lit_dp", 32'(dp), 32'h1);
    step_to(23);  chk("an_digit1", 32'(an), 32'hD);
    step_to(43);  chk("an_digit2", 32'(an), 32'hB);
    step_to(63);  chk("an_digit3", 32'(an), 32'h7);
    step_to(83);  chk("an_wrap", 32'(an), 32'hE);

    step_to(84);  wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h3; wr_dp = 1'b0;
    step_to(85);  wr_en = 1'b0; commit = 1'b1;
    step_to(86);  commit = 1'b0;
                  chk("busy_after_commit", 32'(busy), 32'h1);
    step_to(90);  chk("seg_before_copy", 32'(seg), 32'h40);
    step_to(100); commit = 1'b1;
    step_to(101); commit = 1'b0;
    step_to(158); chk("done_pre_fb", 32'(done), 32'h0);
    step_to(159); chk("done_at_fb", 32'(done), 32'h1);
                  wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h7; wr_dp = 1'b1;
    step_to(160); wr_en = 1'b0;
                  chk("done_cleared", 32'(done), 32'h0);
                  chk("busy_cleared", 32'(busy), 32'h0);
                  d0 = done_cnt;
    step_to(163); chk("seg_new", 32'(seg), 32'h30);
                  chk("an_new", 32'(an), 32'hE);
    step_to(170); commit = 1'b1;
    step_to(171); commit = 1'b0;
    step_to(238); chk("single_done", 32'(done_cnt - d0), 32'h0);
    step_to(239); chk("done_second", 32'(done), 32'h1);
    step_to(243); chk("seg_recommit", 32'(seg), 32'h78);
                  chk("dp_recommit", 32'(dp), 32'h0);

    step_to(250); bright = 3'd1;
    step_to(264);
    n = 0;
    for (int i = 265; i <= 280; i++) begin
      step_to(i);
      if (an == 4'b1101) n++;
    end
    chk("bright1_duty", 32'(n), 32'd4);

    step_to(290); bright = 3'd7; blank = 4'b0100;
    n = 0;
    for (int i = 291; i <= 380; i++) begin
      step_to(i);
      if (an == 4'b1011) n++;
    end
    chk("blank_digit2", 32'(n), 32'd0);
    blank = 4'b0000;

    step_to(400); commit = 1'b1;
    step_to(401); commit = 1'b0;
                  chk("busy_before_rst", 32'(busy), 32'h1);
    step_to(405); rst_n = 1'b0;
    #1;
    chk("rst_an_immediate", 32'(an), 32'hF);
    chk("rst_busy_immediate", 32'(busy), 32'h0);
    chk("rst_done_immediate", 32'(done), 32'h0);
    blink = 4'b0001;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    k = 0;
    d0 = done_cnt;

    step_to(3);   chk("rst_clears_active", 32'(seg), 32'h40);
    step_to(160);
    n = 0;
    for (int i = 161; i <= 240; i++) begin
      step_to(i);
      if (an == 4'b1110) n++;
    end
`ifdef DISPLAY_BLINK_EN
    exp_f2 = 0;
`else
    exp_f2 = 18;
`endif
    chk("digit0_frame2", 32'(n), 32'(exp_f2));
    chk("no_done_after_rst", 32'(done_cnt - d0), 32'h0);
    step_to(320);
    n = 0;
    for (int i = 321; i <= 400; i++) begin
      step_to(i);
      if (an == 4'b1110) n++;
    end
    chk("digit0_frame4", 32'(n), 32'd18);

    step_to(410);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
